// File: rtl/modarith_arbiter_pkg.sv
// Shared types for the modular add/sub arbiter: controller states and unit opcodes.
package ecpa_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  // Index that follows idx in round-robin order, wrapping at nreq.
  function automatic int rr_next(input int idx, input int nreq);
    return (idx == nreq - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/modarith_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after the pointer.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    // Walk offsets from farthest to nearest so the nearest valid requester wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      int          j;
      logic [IW-1:0] cand;
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      cand = IW'(j);
      if (i_valid[cand]) begin
        o_idx = cand;
        o_any = 1'b1;
      end
    end
    if (o_any) o_grant = NREQ'(1) << o_idx;
  end

endmodule

// File: rtl/modarith_arbiter.sv
// Round-robin sharing of one modular add/sub unit: grant, issue, wait with watchdog,
// then return the registered result (or a timeout error) to the owning requester.
module modarith_arbiter
  import ecpa_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [W-1:0]      i_p,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [NREQ-1:0]   i_req_op,
  input  logic [NREQ*W-1:0] i_req_a,
  input  logic [NREQ*W-1:0] i_req_b,
  output logic [NREQ-1:0]   o_req_ack,
  output logic              o_unit_start,
  output logic              o_unit_op,
  output logic [W-1:0]      o_unit_a,
  output logic [W-1:0]      o_unit_b,
  output logic [W-1:0]      o_unit_p,
  input  logic              i_unit_done,
  input  logic [W-1:0]      i_unit_result,
  output logic [NREQ-1:0]   o_rsp_valid,
  output logic [W-1:0]      o_rsp_result,
  output logic              o_rsp_err,
  output logic              o_busy
);

  localparam int IW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  owner_q, owner_d;
  op_t            op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   result_q, result_d;
  logic           err_q, err_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_any;
  logic [IW-1:0]   ptr_after_grant;
  logic [WDW-1:0]  wd_inc;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_valid (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant),
    .o_idx   (grant_idx),
    .o_any   (grant_any)
  );

  assign ptr_after_grant = IW'(rr_next(int'(grant_idx), NREQ));
  // Saturating increment: the watchdog holds at TIMEOUT rather than wrapping.
  assign wd_inc = (wd_q == WDW'(TIMEOUT)) ? wd_q : wd_q + WDW'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d = grant_idx;
          op_d    = i_req_op[grant_idx] ? OP_SUB : OP_ADD;
          a_d     = i_req_a[grant_idx*W +: W];
          b_d     = i_req_b[grant_idx*W +: W];
          ptr_d   = ptr_after_grant;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done on the final watchdog cycle still counts as a good completion.
        if (i_unit_done) begin
          result_d = i_unit_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WDW'(TIMEOUT - 1)) begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  assign o_req_ack    = (state_q == IDLE) ? grant : '0;
  assign o_unit_start = (state_q == ISSUE);
  assign o_unit_op    = op_q;
  assign o_unit_a     = a_q;
  assign o_unit_b     = b_q;
  assign o_unit_p     = i_p;
  assign o_rsp_valid  = (state_q == RESP) ? (NREQ'(1) << owner_q) : '0;
  assign o_rsp_result = result_q;
  assign o_rsp_err    = (state_q == RESP) & err_q;
  assign o_busy       = (state_q != IDLE);

endmodule
